// File: rtl/clk_wiz_rst_seq.sv
// Reset sequencer in front of the 2x clock wizard: holds the PLL in reset, waits for
// a stable lock, retries on timeout, and releases the 200 MHz core reset.
module clk_wiz_rst_seq #(
   parameter int RST_HOLD_CYCLES = 16,
   parameter int LOCK_TIMEOUT    = 1024,
   parameter int STABLE_CYCLES   = 64,
   parameter int MAX_RETRIES     = 3
) (
   input  logic       clk_in1,
   input  logic       resetn,
   input  logic       ext_rst_req,
   input  logic       locked,
   output logic       pll_resetn,
   output logic       sys_resetn,
   output logic       lock_fail,
   output logic [1:0] retry_count
);

   localparam int MAX_A   = (RST_HOLD_CYCLES > LOCK_TIMEOUT) ? RST_HOLD_CYCLES : LOCK_TIMEOUT;
   localparam int MAX_CNT = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
   localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] STAB_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [1:0]       MAX_R     = 2'(MAX_RETRIES);

   typedef enum logic [2:0] {
      ST_HOLD, ST_WAIT_LOCK, ST_STABILIZE, ST_RUN, ST_FAIL
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pll_q, pll_d;
   logic             sys_q, sys_d;
   logic             fail_q, fail_d;
   logic [1:0]       retry_q, retry_d;
   logic [1:0]       retry_inc;
   logic [1:0]       sync_q;
   logic             locked_s;

   assign locked_s = sync_q[1];

   always_ff @(posedge clk_in1 or negedge resetn) begin
      if (!resetn) begin
         sync_q  <= 2'b00;
         state_q <= ST_HOLD;
         cnt_q   <= '0;
         pll_q   <= 1'b0;
         sys_q   <= 1'b0;
         fail_q  <= 1'b0;
         retry_q <= 2'd0;
      end else begin
         sync_q  <= {sync_q[0], locked};
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pll_q   <= pll_d;
         sys_q   <= sys_d;
         fail_q  <= fail_d;
         retry_q <= retry_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pll_d     = pll_q;
      sys_d     = sys_q;
      fail_d    = fail_q;
      retry_d   = retry_q;
      retry_inc = (retry_q == 2'd3) ? 2'd3 : retry_q + 2'd1;

      if (ext_rst_req) begin
         state_d = ST_HOLD;
         cnt_d   = '0;
         pll_d   = 1'b0;
         sys_d   = 1'b0;
         fail_d  = 1'b0;
         retry_d = 2'd0;
      end else begin
         case (state_q)
            ST_HOLD: begin
               pll_d = 1'b0;
               sys_d = 1'b0;
               if (cnt_q == HOLD_LAST) begin
                  state_d = ST_WAIT_LOCK;
                  pll_d   = 1'b1;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            ST_WAIT_LOCK: begin
               // lock takes precedence over a timeout landing on the same edge
               if (locked_s) begin
                  state_d = ST_STABILIZE;
                  cnt_d   = '0;
               end else if (cnt_q == TO_LAST) begin
                  retry_d = retry_inc;
                  cnt_d   = '0;
                  pll_d   = 1'b0;
                  if (retry_inc == MAX_R) begin
                     state_d = ST_FAIL;
                     fail_d  = 1'b1;
                  end else begin
                     state_d = ST_HOLD;
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            ST_STABILIZE: begin
               if (!locked_s) begin
                  state_d = ST_WAIT_LOCK;
                  cnt_d   = '0;
               end else if (cnt_q == STAB_LAST) begin
                  state_d = ST_RUN;
                  sys_d   = 1'b1;
                  retry_d = 2'd0;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            ST_RUN: begin
               if (!locked_s) begin
                  state_d = ST_HOLD;
                  cnt_d   = '0;
                  sys_d   = 1'b0;
                  pll_d   = 1'b0;
               end
            end
            ST_FAIL: begin
               pll_d  = 1'b0;
               sys_d  = 1'b0;
               fail_d = 1'b1;
            end
            default: begin
               state_d = ST_HOLD;
               cnt_d   = '0;
            end
         endcase
      end
   end

   assign pll_resetn  = pll_q;
   assign sys_resetn  = sys_q;
   assign lock_fail   = fail_q;
   assign retry_count = retry_q;

endmodule

// File: tb/tb_clk_wiz_rst_seq.sv
// Bench for clk_wiz_rst_seq: expected outputs per clock edge come from closed-form
// timing rules (attempt lengths, synchronizer delay) with randomized event times.
module tb_clk_wiz_rst_seq;

   localparam int HOLD_N = 16;
   localparam int TO_N   = 1024;
   localparam int STAB_N = 64;
   localparam int MAXR   = 3;
   localparam int ATT    = HOLD_N + TO_N;
   localparam int SYS_AT = HOLD_N + 1 + STAB_N;

   logic       clk_in1 = 1'b0;
   logic       resetn = 1'b0;
   logic       ext_rst_req = 1'b0;
   logic       locked = 1'b0;
   logic       pll_resetn, sys_resetn, lock_fail;
   logic [1:0] retry_count;

   int total = 0;
   int bad   = 0;
   int e     = 0;

   always #5 clk_in1 = ~clk_in1;

   clk_wiz_rst_seq #(
      .RST_HOLD_CYCLES(HOLD_N),
      .LOCK_TIMEOUT   (TO_N),
      .STABLE_CYCLES  (STAB_N),
      .MAX_RETRIES    (MAXR)
   ) dut (
      .clk_in1    (clk_in1),
      .resetn     (resetn),
      .ext_rst_req(ext_rst_req),
      .locked     (locked),
      .pll_resetn (pll_resetn),
      .sys_resetn (sys_resetn),
      .lock_fail  (lock_fail),
      .retry_count(retry_count)
   );

   task automatic step();
      @(posedge clk_in1);
      e++;
      #1;
   endtask

   task automatic chk(input string tag, input logic [1:0] got, input logic [1:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s edge=%0d got=%0d expected=%0d", tag, e, got, exp);
      end
   endtask

   task automatic chk4(input string tag, input logic p, input logic s, input logic l,
                       input logic [1:0] r);
      chk({tag, ".pll_resetn"},  {1'b0, pll_resetn}, {1'b0, p});
      chk({tag, ".sys_resetn"},  {1'b0, sys_resetn}, {1'b0, s});
      chk({tag, ".lock_fail"},   {1'b0, lock_fail},  {1'b0, l});
      chk({tag, ".retry_count"}, retry_count,        r);
   endtask

   // Lock never arrives: each attempt is HOLD_N low cycles then TO_N high cycles.
   function automatic logic nl_pll(input int t);
      return (t >= HOLD_N) && (t < MAXR * ATT) && (((t - HOLD_N) % ATT) < TO_N);
   endfunction

   function automatic logic [1:0] nl_rc(input int t);
      int a;
      a = t / ATT;
      return (a >= MAXR) ? 2'(MAXR) : 2'(a);
   endfunction

   task automatic restart(input logic lk);
      resetn = 1'b0;
      locked = lk;
      ext_rst_req = 1'b0;
      #1;
      chk4("reset_async", 1'b0, 1'b0, 1'b0, 2'd0);
      step();
      step();
      chk4("reset_held", 1'b0, 1'b0, 1'b0, 2'd0);
      resetn = 1'b1;
      e = 0;
   endtask

   int k, e0, d, dd, m, p, h, b, l, s;

   initial begin
      // reset state and clean lock
      locked = 1'b1;
      #2;
      chk4("reset_t0", 1'b0, 1'b0, 1'b0, 2'd0);
      restart(1'b1);
      while (e < SYS_AT + 10) begin
         step();
         chk4("clean", e >= HOLD_N, e >= SYS_AT, 1'b0, 2'd0);
      end

      // asynchronous reset in the middle of STABILIZE
      restart(1'b1);
      k = int'($urandom_range(20, 75));
      while (e < k) begin
         step();
         chk4("pre_arst", e >= HOLD_N, 1'b0, 1'b0, 2'd0);
      end
      #2 resetn = 1'b0;
      #1 chk4("arst_mid_stab", 1'b0, 1'b0, 1'b0, 2'd0);
      step();
      chk4("arst_held", 1'b0, 1'b0, 1'b0, 2'd0);

      // lock drops briefly during STABILIZE
      restart(1'b1);
      e0 = int'($urandom_range(20, 75));
      d  = int'($urandom_range(1, 4));
      s  = e0 + d + 3 + STAB_N;
      while (e < s + 5) begin
         step();
         if (e == e0) locked = 1'b0;
         if (e == e0 + d) locked = 1'b1;
         chk4("stab_drop", e >= HOLD_N, e >= s, 1'b0, 2'd0);
      end

      // lock loss while running: full sequence restarts 3 edges later
      dd = e + int'($urandom_range(1, 20));
      m  = int'($urandom_range(1, 12));
      b  = dd + 3;
      while (e < b + SYS_AT + 5) begin
         step();
         if (e == dd) locked = 1'b0;
         if (e == dd + m) locked = 1'b1;
         if (e < b) chk4("run_pre_loss", 1'b1, 1'b1, 1'b0, 2'd0);
         else       chk4("run_loss", (e - b) >= HOLD_N, (e - b) >= SYS_AT, 1'b0, 2'd0);
      end

      // lock never asserts: three attempts then FAIL
      restart(1'b0);
      while (e < MAXR * ATT + 10) begin
         step();
         chk4("no_lock", nl_pll(e), 1'b0, e >= MAXR * ATT, nl_rc(e));
      end

      // recovery from FAIL by an ext_rst_req pulse of random width
      locked = 1'b1;
      p = e + int'($urandom_range(2, 10));
      h = int'($urandom_range(1, 5));
      b = p + h;
      while (e < b + SYS_AT + 5) begin
         step();
         if (e == p) ext_rst_req = 1'b1;
         if (e == p + h) ext_rst_req = 1'b0;
         if (e <= p) chk4("fail_hold", 1'b0, 1'b0, 1'b1, 2'd3);
         else        chk4("recover", (e - b) >= HOLD_N, (e - b) >= SYS_AT, 1'b0, 2'd0);
      end

      // lock arrives during the second attempt (random), then exactly on its timeout edge
      for (int pass = 0; pass < 2; pass++) begin
         restart(1'b0);
         l = (pass == 0) ? 1054 + int'($urandom_range(0, 1022)) : 2 * ATT - 3;
         s = l + 3 + STAB_N;
         while (e < s + 5) begin
            step();
            if (e == l) locked = 1'b1;
            if (e < l + 3) chk4("late_lock_pre", nl_pll(e), 1'b0, 1'b0, nl_rc(e));
            else           chk4("late_lock", 1'b1, e >= s, 1'b0, (e >= s) ? 2'd0 : 2'd1);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
